// File: rtl/ibuf_pkg.sv
// rtl/ibuf_pkg.sv - shared sizing helper for the ibuf input-conditioning block
package ibuf_pkg;

    // Counter width able to hold 0..filter_len, never narrower than one bit.
    function automatic int filter_cnt_width(input int filter_len);
        return (filter_len <= 1) ? 1 : $clog2(filter_len + 1);
    endfunction

endpackage

// File: rtl/ibuf_bit_filter.sv
// rtl/ibuf_bit_filter.sv - one-bit synchronizer, deglitch filter and edge strobes
module ibuf_bit_filter
    import ibuf_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 4,
    parameter logic INIT        = 1'b0
) (
    input  logic osc,
    input  logic rst,
    input  logic i,
    output logic i_sync,
    output logic i_filt,
    output logic rise,
    output logic fall
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic filt_d;

    always_ff @(posedge osc) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i};
        end
    end

    assign i_sync = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign i_filt = i_sync;
        end else begin : g_filter
            localparam int            CW   = filter_cnt_width(FILTER_LEN);
            localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

            logic [CW-1:0] cnt;
            logic          filt_q;

            // Any edge where the input agrees with the output restarts the run.
            always_ff @(posedge osc) begin
                if (rst) begin
                    cnt    <= '0;
                    filt_q <= INIT;
                end else if (i_sync == filt_q) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt    <= '0;
                    filt_q <= i_sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign i_filt = filt_q;
        end
    endgenerate

    always_ff @(posedge osc) begin
        if (rst) begin
            filt_d <= INIT;
        end else begin
            filt_d <= i_filt;
        end
    end

    assign rise = i_filt & ~filt_d;
    assign fall = ~i_filt & filt_d;

endmodule

// File: rtl/ibuf.sv
// rtl/ibuf.sv - input buffer with pass-through, synchronized, filtered and edge outputs
module ibuf #(
    parameter int   WIDTH       = 1,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 4,
    parameter logic INIT        = 1'b0
) (
    input  logic             osc,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] I_sync,
    output logic [WIDTH-1:0] I_filt,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Primitive buffer behaviour: no clock or reset in this path.
    assign O = I;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        ibuf_bit_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .INIT        (INIT)
        ) u_bit (
            .osc    (osc),
            .rst    (rst),
            .i      (I[b]),
            .i_sync (I_sync[b]),
            .i_filt (I_filt[b]),
            .rise   (rise[b]),
            .fall   (fall[b])
        );
    end

endmodule

// File: tb/tb_ibuf.sv
// tb/tb_ibuf.sv - self-checking bench for ibuf (8-bit filtered and 1-bit bypass instances)
module tb_ibuf;

    localparam int SA = 2;
    localparam int FA = 4;

    logic       osc = 1'b0;
    logic       rst;
    logic [7:0] ia;
    logic       ib;

    logic [7:0] a_o, a_sync, a_filt, a_rise, a_fall;
    logic       b_o, b_sync, b_filt, b_rise, b_fall;

    int tests = 0;
    int fails = 0;
    int rc = 0, fc = 0, hc = 0;

    always #10 osc = ~osc;

    ibuf #(.WIDTH(8), .SYNC_STAGES(SA), .FILTER_LEN(FA), .INIT(1'b0)) dut_a (
        .osc(osc), .rst(rst), .I(ia), .O(a_o),
        .I_sync(a_sync), .I_filt(a_filt), .rise(a_rise), .fall(a_fall)
    );

    ibuf #(.WIDTH(1), .SYNC_STAGES(2), .FILTER_LEN(0), .INIT(1'b0)) dut_b (
        .osc(osc), .rst(rst), .I(ib), .O(b_o),
        .I_sync(b_sync), .I_filt(b_filt), .rise(b_rise), .fall(b_fall)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: input history since reset, sync = value sampled SA edges ago,
    // filtered bit flips once the last FA pre-edge sync values all disagreed with it.
    logic [7:0] hist_a[$];
    logic [7:0] pres_a[$];
    logic       hist_b[$];
    logic [7:0] m_sync_a, m_filt_a, m_fd_a;
    logic       m_sync_b, m_filt_b, m_fd_b;
    logic       mvalid = 1'b0;

    always @(posedge osc) begin
        if (rst) begin
            hist_a.delete();
            pres_a.delete();
            hist_b.delete();
            m_sync_a = 8'h00; m_filt_a = 8'h00; m_fd_a = 8'h00;
            m_sync_b = 1'b0;  m_filt_b = 1'b0;  m_fd_b = 1'b0;
            mvalid = 1'b1;
        end else begin
            pres_a.push_back(m_sync_a);
            hist_a.push_back(ia);
            m_fd_a = m_filt_a;
            for (int b = 0; b < 8; b++) begin
                if (pres_a.size() >= FA) begin
                    logic all_diff;
                    all_diff = 1'b1;
                    for (int k = 1; k <= FA; k++)
                        if (pres_a[pres_a.size()-k][b] == m_fd_a[b]) all_diff = 1'b0;
                    if (all_diff) m_filt_a[b] = ~m_fd_a[b];
                end
            end
            m_sync_a = (hist_a.size() >= SA) ? hist_a[hist_a.size()-SA] : 8'h00;
            if (hist_a.size() > 8) void'(hist_a.pop_front());
            if (pres_a.size() > 8) void'(pres_a.pop_front());

            hist_b.push_back(ib);
            m_fd_b   = m_filt_b;
            m_sync_b = (hist_b.size() >= 2) ? hist_b[hist_b.size()-2] : 1'b0;
            m_filt_b = m_sync_b;
            if (hist_b.size() > 8) void'(hist_b.pop_front());
        end
    end

    always @(negedge osc) begin
        check("a_O", a_o, ia);
        check("b_O", {7'b0, b_o}, {7'b0, ib});
        if (mvalid) begin
            check("a_sync", a_sync, m_sync_a);
            check("a_filt", a_filt, m_filt_a);
            check("a_rise", a_rise, m_filt_a & ~m_fd_a);
            check("a_fall", a_fall, ~m_filt_a & m_fd_a);
            check("b_sync", {7'b0, b_sync}, {7'b0, m_sync_b});
            check("b_filt", {7'b0, b_filt}, {7'b0, m_filt_b});
            check("b_rise", {7'b0, b_rise}, {7'b0, m_filt_b & ~m_fd_b});
            check("b_fall", {7'b0, b_fall}, {7'b0, ~m_filt_b & m_fd_b});
            if (a_rise[0]) rc++;
            if (a_fall[0]) fc++;
            if (a_filt[0]) hc++;
        end
    end

    task automatic tick();
        @(posedge osc);
        #2;
    endtask

    initial begin
        rst = 1'b1; ia = 8'h01; ib = 1'b1;
        tick(); tick(); tick();
        check("rst_sync", a_sync, 8'h00);
        check("rst_filt", a_filt, 8'h00);
        check("rst_rise", a_rise, 8'h00);
        check("rst_b_sync", {7'b0, b_sync}, 8'h00);
        rst = 1'b0;
        tick();
        check("e1_sync", a_sync, 8'h00);
        tick();
        check("e2_sync", a_sync, 8'h01);
        check("e2_filt", a_filt, 8'h00);
        check("e2_b_rise", {7'b0, b_rise}, 8'h01);
        tick(); tick(); tick();
        check("e5_filt", a_filt, 8'h00);
        tick();
        check("e6_filt", a_filt, 8'h01);
        check("e6_rise", a_rise, 8'h01);
        tick();
        check("e7_rise", a_rise, 8'h00);
        check("e7_filt", a_filt, 8'h01);

        ia = 8'h00; repeat (10) tick();
        rc = 0; fc = 0; hc = 0;
        ia = 8'h01; repeat (3) tick();
        ia = 8'h00; repeat (10) tick();
        check("p3_rise_cnt", 8'(rc), 8'd0);
        check("p3_fall_cnt", 8'(fc), 8'd0);
        check("p3_high_cnt", 8'(hc), 8'd0);
        rc = 0; fc = 0; hc = 0;
        ia = 8'h01; repeat (4) tick();
        ia = 8'h00; repeat (10) tick();
        check("p4_rise_cnt", 8'(rc), 8'd1);
        check("p4_fall_cnt", 8'(fc), 8'd1);
        check("p4_high_cnt", 8'(hc), 8'd4);

        ia = 8'hA5; repeat (10) tick();
        ia = 8'h5A; repeat (5) tick();
        check("bus5_filt", a_filt, 8'hA5);
        tick();
        check("bus6_filt", a_filt, 8'h5A);
        check("bus6_rise", a_rise, 8'h5A);
        check("bus6_fall", a_fall, 8'hA5);
        tick();
        check("bus7_rise", a_rise, 8'h00);

        ia = 8'h00; repeat (10) tick();
        ia = 8'hFF; repeat (4) tick();
        rst = 1'b1; tick();
        check("mid_rst_filt", a_filt, 8'h00);
        check("mid_rst_rise", a_rise, 8'h00);
        rst = 1'b0; repeat (5) tick();
        check("mid_e5_filt", a_filt, 8'h00);
        tick();
        check("mid_e6_filt", a_filt, 8'hFF);
        check("mid_e6_rise", a_rise, 8'hFF);

        repeat (60) begin
            ia  = 8'($urandom);
            ib  = 1'($urandom);
            rst = ($urandom_range(0, 9) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
